// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and data bundle between upstream issue logic, the
// alu_issue_stage skid buffer and the ALU result multiplexer.
//   in_*    : upstream entry (valid/ready, operands, 3-bit command)
//   out_*   : registered entry toward the ALU plus pre-decoded mux select/sub
//   stat_*  : 16-bit statistics counters (zero unless ALU_ISSUE_STATS_EN)
// Modports: slave = the stage itself, master = the environment around it.
interface alu_issue_if #(
  parameter int WIDTH     = 32,
  parameter int CMD_WIDTH = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [CMD_WIDTH-1:0] in_cmd;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_a;
  logic [WIDTH-1:0]     out_b;
  logic [CMD_WIDTH-1:0] out_cmd;
  logic [1:0]           out_sel;
  logic                 out_sub;
  logic [15:0]          stat_issued;
  logic [15:0]          stat_stalls;

  modport slave (
    input  in_valid, in_a, in_b, in_cmd, out_ready,
    output in_ready, out_valid, out_a, out_b, out_cmd, out_sel, out_sub,
           stat_issued, stat_stalls
  );

  modport master (
    output in_valid, in_a, in_b, in_cmd, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_cmd, out_sel, out_sub,
           stat_issued, stat_stalls
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: elastic 2-entry skid buffer in front of the ALU result mux.
// Operands and command are registered; the mux select and subtract-mode bit
// are decoded on entry and stored with each entry, so nothing on the output
// side depends combinationally on in_cmd. Ready/valid come from state only.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : alu_issue_if.slave (in_* handshake, out_* handshake, stat_*)
// Optional build macro: ALU_ISSUE_STATS_EN adds saturating issue/stall
// counters; without it stat_issued/stat_stalls are constant 0.
module alu_issue_stage #(
  parameter int WIDTH     = 32,
  parameter int CMD_WIDTH = 3
) (
  input  logic      clk,
  input  logic      reset,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     main_a_q, main_b_q, skid_a_q, skid_b_q;
  logic [CMD_WIDTH-1:0] main_cmd_q, skid_cmd_q;
  logic [1:0]           main_sel_q, skid_sel_q;
  logic                 main_sub_q, skid_sub_q;

  logic       in_fire, out_fire;
  logic       load_main_in, load_main_skid, load_skid;
  logic [1:0] in_sel;
  logic       in_sub;

  // Command decode: ADD/SUB->0, XOR->1, SLT->2, logic ops->3.
  always_comb begin
    in_sel = 2'd3;
    in_sub = 1'b0;
    case (bus.in_cmd)
      3'd0: in_sel = 2'd0;
      3'd1: begin in_sel = 2'd0; in_sub = 1'b1; end
      3'd2: in_sel = 2'd1;
      3'd3: begin in_sel = 2'd2; in_sub = 1'b1; end
      default: in_sel = 2'd3;
    endcase
  end

  assign bus.in_ready  = (state_q != TWO) & ~reset;
  assign bus.out_valid = (state_q != EMPTY);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: if (in_fire) begin
        load_main_in = 1'b1;
        state_d      = ONE;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        load_main_skid = 1'b1;
        state_d        = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_a_q   <= '0;
      main_b_q   <= '0;
      main_cmd_q <= '0;
      main_sel_q <= '0;
      main_sub_q <= 1'b0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_cmd_q <= '0;
      skid_sel_q <= '0;
      skid_sub_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_a_q   <= bus.in_a;
        main_b_q   <= bus.in_b;
        main_cmd_q <= bus.in_cmd;
        main_sel_q <= in_sel;
        main_sub_q <= in_sub;
      end else if (load_main_skid) begin
        main_a_q   <= skid_a_q;
        main_b_q   <= skid_b_q;
        main_cmd_q <= skid_cmd_q;
        main_sel_q <= skid_sel_q;
        main_sub_q <= skid_sub_q;
      end
      if (load_skid) begin
        skid_a_q   <= bus.in_a;
        skid_b_q   <= bus.in_b;
        skid_cmd_q <= bus.in_cmd;
        skid_sel_q <= in_sel;
        skid_sub_q <= in_sub;
      end
    end
  end

  assign bus.out_a   = main_a_q;
  assign bus.out_b   = main_b_q;
  assign bus.out_cmd = main_cmd_q;
  assign bus.out_sel = main_sel_q;
  assign bus.out_sub = main_sub_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_q, stalls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q <= '0;
      stalls_q <= '0;
    end else begin
      if (out_fire && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      if (bus.out_valid && !bus.out_ready && stalls_q != 16'hFFFF)
        stalls_q <= stalls_q + 16'd1;
    end
  end

  assign bus.stat_issued = issued_q;
  assign bus.stat_stalls = stalls_q;
`else
  assign bus.stat_issued = 16'd0;
  assign bus.stat_stalls = 16'd0;
`endif

endmodule
